// File: rtl/tx_arp_gen_if.sv
// Signal bundle between the ARP transmit generator and its environment:
// configuration, trigger pulses and the framed 32-bit payload stream.
interface tx_arp_gen_if;
  logic [47:0] cfg_mac_local;
  logic [31:0] cfg_ip_local;
  logic [31:0] cfg_ip_pc;
  logic [47:0] cfg_mac_pc;
  logic        ack_en;
  logic        req_en;
  logic        dout_rdy;
  logic [31:0] dout_data;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic [1:0]  dout_mod;
  logic        busy;

  // Generator side
  modport master (
    input  cfg_mac_local, cfg_ip_local, cfg_ip_pc, cfg_mac_pc,
    input  ack_en, req_en, dout_rdy,
    output dout_data, dout_vld, dout_sop, dout_eop, dout_mod, busy
  );

  // Environment side: configuration/trigger source and stream sink
  modport slave (
    output cfg_mac_local, cfg_ip_local, cfg_ip_pc, cfg_mac_pc,
    output ack_en, req_en, dout_rdy,
    input  dout_data, dout_vld, dout_sop, dout_eop, dout_mod, busy
  );
endinterface

// File: rtl/tx_arp_gen.sv
// ARP request/reply payload generator: snapshots the addressing fields on packet
// start and streams the 28-byte body (optionally padded to 46 bytes) as framed words.
module tx_arp_gen #(
  parameter int DATA_W     = 32,
  parameter int MAC_ADDR_W = 48,
  parameter int IP_ADDR_W  = 32,
  parameter int PAD_EN     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  tx_arp_gen_if.master  io_arp
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [3:0]  LAST_CNT = (PAD_EN != 0) ? 4'd11 : 4'd6;
  localparam logic [1:0]  EOP_MOD  = (PAD_EN != 0) ? 2'd2 : 2'd0;
  localparam logic [15:0] OPER_REQ = 16'd1;
  localparam logic [15:0] OPER_REP = 16'd2;
  localparam logic [DATA_W-1:0] WORD0 = 32'h0001_0800;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_pend_ack;
  logic                  r_pend_req;
  logic [15:0]           r_oper;
  logic [MAC_ADDR_W-1:0] r_sha;
  logic [IP_ADDR_W-1:0]  r_spa;
  logic [MAC_ADDR_W-1:0] r_tha;
  logic [IP_ADDR_W-1:0]  r_tpa;
  logic [DATA_W-1:0]     r_data;
  logic                  r_vld;
  logic                  r_sop;
  logic                  r_eop;
  logic [1:0]            r_mod;
  logic                  r_busy;

  logic                  w_start_ack;
  logic                  w_start_req;
  logic                  w_xfer;
  logic [3:0]            w_next_cnt;
  logic [DATA_W-1:0]     w_next_word;

  // Payload word at a given position; padding positions read as zero.
  function automatic logic [DATA_W-1:0] word_at(
    input logic [3:0]            idx,
    input logic [15:0]           oper,
    input logic [MAC_ADDR_W-1:0] sha,
    input logic [IP_ADDR_W-1:0]  spa,
    input logic [MAC_ADDR_W-1:0] tha,
    input logic [IP_ADDR_W-1:0]  tpa
  );
    logic [DATA_W-1:0] w;
    case (idx)
      4'd0:    w = WORD0;
      4'd1:    w = {8'h06, 8'h04, oper};
      4'd2:    w = sha[47:16];
      4'd3:    w = {sha[15:0], spa[31:16]};
      4'd4:    w = {spa[15:0], tha[47:32]};
      4'd5:    w = tha[31:0];
      4'd6:    w = tpa;
      default: w = {DATA_W{1'b0}};
    endcase
    return w;
  endfunction

  // Start decisions and next-word lookup from the snapshotted fields.
  always_comb begin
    w_start_ack = r_pend_ack | io_arp.ack_en;
    w_start_req = r_pend_req | io_arp.req_en;
    w_xfer      = r_vld & io_arp.dout_rdy;
    w_next_cnt  = r_cnt + 4'd1;
    w_next_word = word_at(w_next_cnt, r_oper, r_sha, r_spa, r_tha, r_tpa);
  end

  // Control FSM with registered stream outputs and trigger bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_pend_ack <= 1'b0;
      r_pend_req <= 1'b0;
      r_oper     <= 16'd0;
      r_sha      <= {MAC_ADDR_W{1'b0}};
      r_spa      <= {IP_ADDR_W{1'b0}};
      r_tha      <= {MAC_ADDR_W{1'b0}};
      r_tpa      <= {IP_ADDR_W{1'b0}};
      r_data     <= {DATA_W{1'b0}};
      r_vld      <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_mod      <= 2'd0;
      r_busy     <= 1'b0;
    end else begin
      // Pulses always latch; a starting packet clears only its own flag below.
      r_pend_ack <= r_pend_ack | io_arp.ack_en;
      r_pend_req <= r_pend_req | io_arp.req_en;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ack || w_start_req) begin
            if (w_start_ack) begin
              r_pend_ack <= 1'b0;
              r_oper     <= OPER_REP;
              r_tha      <= io_arp.cfg_mac_pc;
            end else begin
              r_pend_req <= 1'b0;
              r_oper     <= OPER_REQ;
              r_tha      <= {MAC_ADDR_W{1'b0}};
            end
            r_sha   <= io_arp.cfg_mac_local;
            r_spa   <= io_arp.cfg_ip_local;
            r_tpa   <= io_arp.cfg_ip_pc;
            r_state <= ST_SEND;
            r_cnt   <= 4'd0;
            r_data  <= WORD0;
            r_vld   <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= 1'b0;
            r_mod   <= 2'd0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (r_eop) begin
              // Dropping vld here guarantees one idle cycle before the next packet.
              r_state <= ST_IDLE;
              r_cnt   <= 4'd0;
              r_data  <= {DATA_W{1'b0}};
              r_vld   <= 1'b0;
              r_sop   <= 1'b0;
              r_eop   <= 1'b0;
              r_mod   <= 2'd0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt  <= w_next_cnt;
              r_data <= w_next_word;
              r_sop  <= 1'b0;
              r_eop  <= (w_next_cnt == LAST_CNT);
              r_mod  <= (w_next_cnt == LAST_CNT) ? EOP_MOD : 2'd0;
            end
          end else begin
            r_state <= ST_SEND;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_arp.dout_data = r_data;
  assign io_arp.dout_vld  = r_vld;
  assign io_arp.dout_sop  = r_sop;
  assign io_arp.dout_eop  = r_eop;
  assign io_arp.dout_mod  = r_mod;
  assign io_arp.busy      = r_busy;

endmodule

// File: tb/tb_tx_arp_gen.sv
// Scoreboard bench for tx_arp_gen: an unpadded and a padded instance, expected
// words built byte-by-byte from the ARP field layout and popped by a stream monitor.
module tb_tx_arp_gen;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  bit   stall_mode;

  exp_t q0[$];
  exp_t q1[$];

  tx_arp_gen_if if0 ();
  tx_arp_gen_if if1 ();

  tx_arp_gen #(.PAD_EN(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .io_arp(if0.master));
  tx_arp_gen #(.PAD_EN(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_arp(if1.master));

  logic [31:0] m_data [2];
  logic [1:0]  m_mod  [2];
  logic [1:0]  m_vld, m_sop, m_eop, m_rdy, m_busy;

  assign m_data[0] = if0.dout_data;
  assign m_data[1] = if1.dout_data;
  assign m_mod[0]  = if0.dout_mod;
  assign m_mod[1]  = if1.dout_mod;
  assign m_vld  = {if1.dout_vld,  if0.dout_vld};
  assign m_sop  = {if1.dout_sop,  if0.dout_sop};
  assign m_eop  = {if1.dout_eop,  if0.dout_eop};
  assign m_rdy  = {if1.dout_rdy,  if0.dout_rdy};
  assign m_busy = {if1.busy,      if0.busy};

  logic [31:0] t1_words [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_word(input int d, input logic [31:0] w, input bit s, input bit e, input logic [1:0] m);
    exp_t x;
    x.data = w; x.sop = s; x.eop = e; x.mod = m;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Reference: lay out the ARP body as bytes, pad, then pack big-endian into words.
  task automatic push_pkt(input int d, input bit is_reply, input logic [47:0] sha,
                          input logic [31:0] spa, input logic [47:0] mac_pc, input logic [31:0] tpa);
    logic [7:0]  b[$];
    logic [15:0] oper;
    logic [47:0] tha;
    logic [31:0] w;
    int len, nw, idx;
    oper = is_reply ? 16'd2 : 16'd1;
    tha  = is_reply ? mac_pc : 48'h0;
    b = {8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, oper[15:8], oper[7:0]};
    for (int i = 5; i >= 0; i--) b.push_back(sha[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(spa[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(tha[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(tpa[i*8 +: 8]);
    if (d == 1) while (b.size() < 46) b.push_back(8'h00);
    len = b.size();
    nw  = (len + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * k + j;
        w = {w[23:0], (idx < len) ? b[idx] : 8'h00};
      end
      push_word(d, w, k == 0, k == nw - 1, (k == nw - 1) ? 2'(4 * nw - len) : 2'd0);
    end
  endtask

  task automatic set_cfg(input int d, input logic [47:0] sha, input logic [31:0] spa,
                         input logic [47:0] mac_pc, input logic [31:0] tpa);
    if (d == 0) begin
      if0.cfg_mac_local = sha; if0.cfg_ip_local = spa; if0.cfg_mac_pc = mac_pc; if0.cfg_ip_pc = tpa;
    end else begin
      if1.cfg_mac_local = sha; if1.cfg_ip_local = spa; if1.cfg_mac_pc = mac_pc; if1.cfg_ip_pc = tpa;
    end
  endtask

  task automatic drive_pulse(input int d, input bit a, input bit r);
    if (d == 0) begin if0.ack_en = a; if0.req_en = r; end
    else        begin if1.ack_en = a; if1.req_en = r; end
  endtask

  // One-cycle trigger; optionally checks the one-cycle start latency.
  task automatic pulse(input int d, input bit a, input bit r, input bit chk);
    @(posedge clk); #1;
    drive_pulse(d, a, r);
    @(posedge clk); #1;
    drive_pulse(d, 1'b0, 1'b0);
    if (chk) begin
      n_tests++;
      if (!(m_vld[d] && m_sop[d]))
        $display("FAIL latency dut%0d: vld=%0b sop=%0b, required vld=1 sop=1", d, m_vld[d], m_sop[d]);
      if (!(m_vld[d] && m_sop[d])) n_fail++;
    end
  endtask

  task automatic wait_drain(input int d);
    int sz;
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0 && !m_vld[d]) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout dut%0d: %0d words outstanding, required 0", d, (d == 0) ? q0.size() : q1.size());
    end
    repeat (2) @(posedge clk);
  endtask

  // Ready driver: always ready, or a 50% random stall pattern.
  initial begin
    if0.dout_rdy = 1'b1;
    if1.dout_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if0.dout_rdy = stall_mode ? 1'($urandom % 2) : 1'b1;
      if1.dout_rdy = stall_mode ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Monitor: pops expected words on transfers, checks stall stability and inter-packet gap.
  initial begin
    bit   prev_stall [2];
    bit   after_eop  [2];
    logic [36:0] snap [2];
    logic [36:0] cur;
    exp_t got, ex;
    bit   have;
    for (int d = 0; d < 2; d++) begin prev_stall[d] = 1'b0; after_eop[d] = 1'b0; snap[d] = 37'h0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin prev_stall[d] = 1'b0; after_eop[d] = 1'b0; end
      end else begin
        for (int d = 0; d < 2; d++) begin
          cur = {m_vld[d], m_data[d], m_sop[d], m_eop[d], m_mod[d]};
          if (after_eop[d]) begin
            n_tests++;
            if (m_vld[d]) begin
              n_fail++;
              $display("FAIL gap dut%0d: vld=1 right after eop, required 0", d);
            end
          end
          after_eop[d] = 1'b0;
          if (prev_stall[d]) begin
            n_tests++;
            if (cur != snap[d]) begin
              n_fail++;
              $display("FAIL stall_stable dut%0d: got %h, required %h", d, cur, snap[d]);
            end
          end
          if (m_vld[d]) begin
            n_tests++;
            if (!m_busy[d]) begin
              n_fail++;
              $display("FAIL busy dut%0d: busy=0 during packet, required 1", d);
            end
            if (m_rdy[d]) begin
              got.data = m_data[d]; got.sop = m_sop[d]; got.eop = m_eop[d]; got.mod = m_mod[d];
              have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
              n_tests++;
              if (!have) begin
                n_fail++;
                $display("FAIL unexpected_word dut%0d: got %h, required no transfer", d, got);
              end else begin
                ex = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (got != ex) begin
                  n_fail++;
                  $display("FAIL word dut%0d: got data=%h sop=%0b eop=%0b mod=%0d, required data=%h sop=%0b eop=%0b mod=%0d",
                           d, got.data, got.sop, got.eop, got.mod, ex.data, ex.sop, ex.eop, ex.mod);
                end
              end
              after_eop[d] = m_eop[d];
            end
          end
          prev_stall[d] = m_vld[d] && !m_rdy[d];
          snap[d] = cur;
        end
      end
    end
  end

  initial begin
    logic [47:0] sha, mpc;
    logic [31:0] spa, tpa;
    int kind, d;
    n_tests = 0; n_fail = 0; stall_mode = 1'b0;
    t1_words = '{32'h0001_0800, 32'h0604_0001, 32'h000A_3501, 32'hFEC0_C0A8,
                 32'h0002_0000, 32'h0000_0000, 32'hC0A8_0003};
    rst_n = 1'b0;
    drive_pulse(0, 1'b0, 1'b0);
    drive_pulse(1, 1'b0, 1'b0);
    set_cfg(0, 48'h000A_3501_FEC0, 32'hC0A8_0002, 48'h0, 32'hC0A8_0003);
    set_cfg(1, 48'h000A_3501_FEC0, 32'hC0A8_0002, 48'h0, 32'hC0A8_0003);
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({m_vld[k], m_sop[k], m_eop[k], m_mod[k], m_data[k], m_busy[k]} != 38'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d: vld=%0b data=%h busy=%0b, required all 0", k, m_vld[k], m_data[k], m_busy[k]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Plain request with the reference addresses
    for (int i = 0; i < 7; i++) push_word(0, t1_words[i], i == 0, i == 6, 2'd0);
    pulse(0, 1'b0, 1'b1, 1'b1);
    wait_drain(0);

    // Reply carrying the PC's MAC
    set_cfg(0, 48'h000A_3501_FEC0, 32'hC0A8_0002, 48'h1122_3344_5566, 32'hC0A8_0003);
    for (int i = 0; i < 7; i++)
      push_word(0, (i == 1) ? 32'h0604_0002 : (i == 4) ? 32'h0002_1122 : (i == 5) ? 32'h3344_5566 : t1_words[i],
                i == 0, i == 6, 2'd0);
    pulse(0, 1'b1, 1'b0, 1'b1);
    wait_drain(0);

    // Simultaneous triggers: reply first, then exactly one request
    push_pkt(0, 1'b1, 48'h000A_3501_FEC0, 32'hC0A8_0002, 48'h1122_3344_5566, 32'hC0A8_0003);
    push_pkt(0, 1'b0, 48'h000A_3501_FEC0, 32'hC0A8_0002, 48'h1122_3344_5566, 32'hC0A8_0003);
    pulse(0, 1'b1, 1'b1, 1'b1);
    wait_drain(0);
    repeat (20) @(posedge clk);

    // Merged requests during a reply, with cfg changed mid-packet
    push_pkt(0, 1'b1, 48'hAABB_CCDD_EEFF, 32'h0A00_0001, 48'h0102_0304_0506, 32'h0A00_0002);
    push_pkt(0, 1'b0, 48'h6655_4433_2211, 32'h0B00_0001, 48'h0, 32'h0B00_0002);
    set_cfg(0, 48'hAABB_CCDD_EEFF, 32'h0A00_0001, 48'h0102_0304_0506, 32'h0A00_0002);
    pulse(0, 1'b1, 1'b0, 1'b1);
    set_cfg(0, 48'h6655_4433_2211, 32'h0B00_0001, 48'h7777_7777_7777, 32'h0B00_0002);
    pulse(0, 1'b0, 1'b1, 1'b0);
    pulse(0, 1'b0, 1'b1, 1'b0);
    wait_drain(0);
    repeat (20) @(posedge clk);

    // Reference request under random back-pressure
    stall_mode = 1'b1;
    set_cfg(0, 48'h000A_3501_FEC0, 32'hC0A8_0002, 48'h1122_3344_5566, 32'hC0A8_0003);
    for (int i = 0; i < 7; i++) push_word(0, t1_words[i], i == 0, i == 6, 2'd0);
    pulse(0, 1'b0, 1'b1, 1'b1);
    wait_drain(0);

    // Padded request on the PAD_EN=1 instance
    set_cfg(1, 48'h000A_3501_FEC0, 32'hC0A8_0002, 48'h1122_3344_5566, 32'hC0A8_0003);
    for (int i = 0; i < 12; i++)
      push_word(1, (i < 7) ? t1_words[i] : 32'h0, i == 0, i == 11, (i == 11) ? 2'd2 : 2'd0);
    pulse(1, 1'b0, 1'b1, 1'b1);
    wait_drain(1);

    // Randomized packets on both instances
    for (int it = 0; it < 24; it++) begin
      d = int'($urandom % 2);
      kind = int'($urandom % 3);
      stall_mode = 1'($urandom % 2);
      sha = {16'($urandom), $urandom};
      mpc = {16'($urandom), $urandom};
      spa = $urandom;
      tpa = $urandom;
      set_cfg(d, sha, spa, mpc, tpa);
      if (kind != 0) push_pkt(d, 1'b1, sha, spa, mpc, tpa);
      if (kind != 1) push_pkt(d, 1'b0, sha, spa, mpc, tpa);
      pulse(d, kind != 0, kind != 1, 1'b1);
      wait_drain(d);
    end

    // Reset in the middle of a packet, then a clean restart
    stall_mode = 1'b0;
    repeat (2) @(posedge clk);
    set_cfg(0, 48'h000A_3501_FEC0, 32'hC0A8_0002, 48'h1122_3344_5566, 32'hC0A8_0003);
    for (int i = 0; i < 7; i++) push_word(0, t1_words[i], i == 0, i == 6, 2'd0);
    pulse(0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (m_data[0] != t1_words[3]) begin
      n_fail++;
      $display("FAIL mid_packet dut0: data=%h, required %h", m_data[0], t1_words[3]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({m_vld[0], m_sop[0], m_eop[0], m_mod[0], m_data[0], m_busy[0]} != 38'h0) begin
      n_fail++;
      $display("FAIL async_reset dut0: vld=%0b data=%h busy=%0b, required all 0", m_vld[0], m_data[0], m_busy[0]);
    end
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 7; i++) push_word(0, t1_words[i], i == 0, i == 6, 2'd0);
    pulse(0, 1'b0, 1'b1, 1'b1);
    wait_drain(0);
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
